// File: rtl/playfield_renderer.sv
// playfield_renderer: scans a column-organised wall bitmap from a
// one-cycle-latency RAM port and emits one pixel write per cycle (walls in
// column-major order, then the player sprite), closing each frame with a
// single-cycle done pulse.
//
// Handshake: i_start is a request sampled only while the FSM is idle; there
// is no ready signal and no queueing, so a request seen while busy is simply
// dropped. o_busy rises the cycle after a request is accepted and stays high
// through the cycle in which o_done pulses. A new request may be accepted on
// the edge right after o_done. o_plot qualifies o_x/o_y/o_colour; while it is
// low those outputs hold their previous values.
module playfield_renderer #(
  parameter int COLS  = 120,
  parameter int ROWS  = 100,
  parameter int X_OFF = 20,
  parameter int Y_OFF = 10,
  parameter int SPR_W = 4,
  parameter int SPR_H = 6,
  parameter int CW    = 3,
  parameter logic [CW-1:0] WALL_C = 3'b111,
  parameter logic [CW-1:0] BG_C   = 3'b000,
  parameter logic [CW-1:0] SPR_C  = 3'b100
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     i_start,
  input  logic                     i_clear,
  input  logic [7:0]               i_spr_x,
  input  logic [7:0]               i_spr_y,
  output logic [$clog2(COLS)-1:0]  o_mem_addr,
  input  logic [ROWS-1:0]          i_mem_data,
  output logic [7:0]               o_x,
  output logic [7:0]               o_y,
  output logic [CW-1:0]            o_colour,
  output logic                     o_plot,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [2:0]               o_state
);

  localparam int AW = $clog2(COLS);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_WALL   = 3'd3,
    S_SPRITE = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_c;
  logic [RW-1:0]   r_r;
  logic [7:0]      r_i;
  logic [7:0]      r_j;
  logic [7:0]      r_sx;
  logic [7:0]      r_sy;
  logic            r_clear;
  logic [ROWS-1:0] r_buf;

  logic [8:0]      w_px9;
  logic [8:0]      w_py9;
  logic            w_spr_vis;
  logic            w_last_row;
  logic            w_last_col;
  logic            w_last_i;
  logic            w_last_j;

  // Sprite pixel position in playfield space, one bit wider than the inputs
  // so a sprite parked near 255 can never wrap back into view.
  assign w_px9      = {1'b0, r_sx} + {1'b0, r_i};
  assign w_py9      = {1'b0, r_sy} + {1'b0, r_j};
  assign w_spr_vis  = (w_px9 < 9'(COLS)) && (w_py9 < 9'(ROWS));
  assign w_last_row = (r_r == RW'(ROWS - 1));
  assign w_last_col = (r_c == AW'(COLS - 1));
  assign w_last_i   = (r_i == 8'(SPR_W - 1));
  assign w_last_j   = (r_j == 8'(SPR_H - 1));
  assign o_state    = r_state;

  // Frame FSM with all pixel/handshake outputs registered one cycle behind
  // the state that produces them.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_c        <= '0;
      r_r        <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_sx       <= '0;
      r_sy       <= '0;
      r_clear    <= 1'b0;
      r_buf      <= '0;
      o_mem_addr <= '0;
      o_x        <= '0;
      o_y        <= '0;
      o_colour   <= '0;
      o_plot     <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_plot <= 1'b0;
      o_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          o_busy <= i_start;
          if (i_start) begin
            r_sx       <= i_spr_x;
            r_sy       <= i_spr_y;
            r_clear    <= i_clear;
            r_c        <= '0;
            o_mem_addr <= '0;
            r_state    <= S_FETCH;
          end
        end
        // Address is already on the RAM port; wait out its one-cycle latency.
        S_FETCH: r_state <= S_LOAD;
        S_LOAD: begin
          r_buf   <= i_mem_data;
          r_r     <= '0;
          r_state <= S_WALL;
        end
        S_WALL: begin
          o_plot   <= 1'b1;
          o_x      <= 8'(X_OFF + int'(r_c));
          o_y      <= 8'(Y_OFF + int'(r_r));
          o_colour <= (r_buf[r_r] && !r_clear) ? WALL_C : BG_C;
          if (w_last_row) begin
            if (w_last_col) begin
              r_i     <= '0;
              r_j     <= '0;
              r_state <= S_SPRITE;
            end else begin
              r_c        <= r_c + 1'b1;
              o_mem_addr <= r_c + 1'b1;
              r_state    <= S_FETCH;
            end
          end else begin
            r_r <= r_r + 1'b1;
          end
        end
        // Clipped pixels still cost a cycle so frame length never varies.
        S_SPRITE: begin
          if (w_spr_vis) begin
            o_plot   <= 1'b1;
            o_x      <= 8'(X_OFF) + r_sx + r_i;
            o_y      <= 8'(Y_OFF) + r_sy + r_j;
            o_colour <= SPR_C;
          end
          if (w_last_j) begin
            r_j <= '0;
            if (w_last_i) r_state <= S_DONE;
            else          r_i     <= r_i + 8'd1;
          end else begin
            r_j <= r_j + 8'd1;
          end
        end
        S_DONE: begin
          o_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_playfield_renderer.sv
// Directed testbench for playfield_renderer (small 4x3 playfield instance
// plus one default-parameter instance for the full-size frame timing).
module tb_playfield_renderer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // ---------------- small DUT ----------------
  logic       i_start = 1'b0;
  logic       i_clear = 1'b0;
  logic [7:0] i_spr_x = '0;
  logic [7:0] i_spr_y = '0;
  logic [1:0] o_mem_addr;
  logic [2:0] i_mem_data;
  logic [7:0] o_x, o_y;
  logic [2:0] o_colour;
  logic       o_plot, o_busy, o_done;
  logic [2:0] o_state;

  playfield_renderer #(
    .COLS(4), .ROWS(3), .X_OFF(20), .Y_OFF(10), .SPR_W(2), .SPR_H(2)
  ) dut (
    .clk(clk), .resetn(resetn), .i_start(i_start), .i_clear(i_clear),
    .i_spr_x(i_spr_x), .i_spr_y(i_spr_y), .o_mem_addr(o_mem_addr),
    .i_mem_data(i_mem_data), .o_x(o_x), .o_y(o_y), .o_colour(o_colour),
    .o_plot(o_plot), .o_busy(o_busy), .o_done(o_done), .o_state(o_state)
  );

  // Synchronous wall RAM, one cycle latency
  logic [2:0] ram [4];
  always_ff @(posedge clk) i_mem_data <= ram[o_mem_addr];

  // ---------------- default-parameter DUT ----------------
  logic        f_start = 1'b0;
  logic [7:0]  f_spr_x = '0;
  logic [7:0]  f_spr_y = '0;
  logic [6:0]  f_mem_addr;
  logic [99:0] f_mem_data = '1;
  logic [7:0]  f_x, f_y;
  logic [2:0]  f_colour;
  logic        f_plot, f_busy, f_done;
  logic [2:0]  f_state;

  playfield_renderer dut_full (
    .clk(clk), .resetn(resetn), .i_start(f_start), .i_clear(1'b0),
    .i_spr_x(f_spr_x), .i_spr_y(f_spr_y), .o_mem_addr(f_mem_addr),
    .i_mem_data(f_mem_data), .o_x(f_x), .o_y(f_y), .o_colour(f_colour),
    .o_plot(f_plot), .o_busy(f_busy), .o_done(f_done), .o_state(f_state)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;

  localparam int N = 64;
  logic       exp_plot [N];
  logic [7:0] exp_x    [N];
  logic [7:0] exp_y    [N];
  logic [2:0] exp_col  [N];
  logic       exp_done [N];
  logic       exp_busy [N];
  logic       obs_plot [N];
  logic [7:0] obs_x    [N];
  logic [7:0] obs_y    [N];
  logic [2:0] obs_col  [N];
  logic       obs_done [N];
  logic       obs_busy [N];
  logic [2:0] obs_state[N];

  // Scenario table: basic, clear, clip, wrap-safe clip
  logic [7:0] tbl_sx  [4] = '{8'd0, 8'd0, 8'd3, 8'd255};
  logic [7:0] tbl_sy  [4] = '{8'd0, 8'd0, 8'd2, 8'd0};
  logic       tbl_clr [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  // ---------------- model: expected per-edge outputs ----------------
  // Index k = value seen after edge k, edge 0 being the start-sampling edge.
  task automatic build_expected(input logic [7:0] sx, input logic [7:0] sy, input logic clr);
    int e;
    logic [2:0] col_word;
    for (int k = 0; k < N; k++) begin
      exp_plot[k] = 1'b0; exp_x[k] = '0; exp_y[k] = '0; exp_col[k] = '0;
      exp_done[k] = (k == 25);
      exp_busy[k] = (k <= 25);
    end
    e = 3;
    for (int c = 0; c < 4; c++) begin
      col_word = ram[c];
      for (int r = 0; r < 3; r++) begin
        exp_plot[e] = 1'b1;
        exp_x[e]    = 8'(20 + c);
        exp_y[e]    = 8'(10 + r);
        exp_col[e]  = (col_word[r] && !clr) ? 3'b111 : 3'b000;
        e++;
      end
      if (c != 3) e += 2;
    end
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        if ((int'(sx) + i) < 4 && (int'(sy) + j) < 3) begin
          exp_plot[e] = 1'b1;
          exp_x[e]    = 8'(20 + int'(sx) + i);
          exp_y[e]    = 8'(10 + int'(sy) + j);
          exp_col[e]  = 3'b100;
        end
        e++;
      end
    end
  endtask

  // ---------------- driver: run a frame and record outputs ----------------
  task automatic capture(input logic [7:0] sx, input logic [7:0] sy, input logic clr,
                         input int n, input int pulse_at, input logic hold);
    @(negedge clk);
    i_spr_x = sx; i_spr_y = sy; i_clear = clr; i_start = 1'b1;
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      obs_plot[k] = o_plot; obs_x[k] = o_x; obs_y[k] = o_y; obs_col[k] = o_colour;
      obs_done[k] = o_done; obs_busy[k] = o_busy; obs_state[k] = o_state;
      i_start = hold || (k + 1 == pulse_at);
      if (k == 0 && !hold) begin
        // latched position must not follow later input changes
        i_spr_x = sx ^ 8'h5a;
        i_spr_y = sy ^ 8'h33;
        i_clear = ~clr;
      end
    end
    i_start = 1'b0;
    i_clear = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({o_plot, o_busy, o_done, o_x, o_y, o_colour, o_mem_addr, o_state} !== '0) begin
      n_err++;
      $display("FAIL reset_values got plot=%0b busy=%0b done=%0b x=%0d y=%0d col=%0d addr=%0d st=%0d exp all 0",
               o_plot, o_busy, o_done, o_x, o_y, o_colour, o_mem_addr, o_state);
    end
    resetn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (o_busy !== 1'b0 || o_state !== 3'd0) begin
      n_err++;
      $display("FAIL reset_idle got busy=%0b state=%0d exp busy=0 state=0", o_busy, o_state);
    end
  endtask

  task automatic test_frames;
    for (int s = 0; s < 4; s++) begin
      build_expected(tbl_sx[s], tbl_sy[s], tbl_clr[s]);
      capture(tbl_sx[s], tbl_sy[s], tbl_clr[s], 27, -1, 1'b0);
      for (int k = 0; k <= 27; k++) begin
        n_cmp++;
        if (obs_plot[k] !== exp_plot[k] || obs_done[k] !== exp_done[k] || obs_busy[k] !== exp_busy[k]) begin
          n_err++;
          $display("FAIL frame%0d_edge%0d_ctrl got plot=%0b done=%0b busy=%0b exp plot=%0b done=%0b busy=%0b",
                   s, k, obs_plot[k], obs_done[k], obs_busy[k], exp_plot[k], exp_done[k], exp_busy[k]);
        end
        if (exp_plot[k]) begin
          n_cmp++;
          if (obs_x[k] !== exp_x[k] || obs_y[k] !== exp_y[k] || obs_col[k] !== exp_col[k]) begin
            n_err++;
            $display("FAIL frame%0d_edge%0d_pixel got (%0d,%0d) c=%0d exp (%0d,%0d) c=%0d",
                     s, k, obs_x[k], obs_y[k], obs_col[k], exp_x[k], exp_y[k], exp_col[k]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    int n_done;
    @(negedge clk);
    i_spr_x = 8'd0; i_spr_y = 8'd0; i_clear = 1'b0; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (9) @(negedge clk);
    n_cmp++;
    if (o_plot !== 1'b1 || o_x !== 8'd21 || o_y !== 8'd11 || o_colour !== 3'b111) begin
      n_err++;
      $display("FAIL midreset_edge9 got plot=%0b (%0d,%0d) c=%0d exp plot=1 (21,11) c=7",
               o_plot, o_x, o_y, o_colour);
    end
    resetn = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({o_plot, o_busy, o_done, o_x, o_y, o_colour, o_mem_addr, o_state} !== '0) begin
      n_err++;
      $display("FAIL midreset_values got plot=%0b busy=%0b done=%0b x=%0d y=%0d col=%0d addr=%0d st=%0d exp all 0",
               o_plot, o_busy, o_done, o_x, o_y, o_colour, o_mem_addr, o_state);
    end
    resetn = 1'b1;
    n_done = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (o_done || o_busy || o_plot) n_done++;
    end
    n_cmp++;
    if (n_done !== 0) begin
      n_err++;
      $display("FAIL midreset_quiet got %0d active cycles exp 0", n_done);
    end
  endtask

  task automatic test_ignore_start;
    int n_plots;
    build_expected(8'd0, 8'd0, 1'b0);
    capture(8'd0, 8'd0, 1'b0, 45, 5, 1'b0);
    n_plots = 0;
    for (int k = 0; k <= 45; k++) begin
      if (obs_plot[k]) n_plots++;
      n_cmp++;
      if (obs_done[k] !== exp_done[k] || obs_busy[k] !== exp_busy[k]) begin
        n_err++;
        $display("FAIL ignore_start_edge%0d got done=%0b busy=%0b exp done=%0b busy=%0b",
                 k, obs_done[k], obs_busy[k], exp_done[k], exp_busy[k]);
      end
    end
    n_cmp++;
    if (n_plots !== 16) begin
      n_err++;
      $display("FAIL ignore_start_plots got %0d exp 16", n_plots);
    end
  endtask

  task automatic test_back_to_back;
    build_expected(8'd0, 8'd0, 1'b0);
    capture(8'd0, 8'd0, 1'b0, 55, -1, 1'b1);
    for (int k = 0; k <= 51; k++) begin
      n_cmp++;
      if (obs_plot[k] !== exp_plot[k % 26] || obs_done[k] !== exp_done[k % 26] || obs_busy[k] !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_edge%0d got plot=%0b done=%0b busy=%0b exp plot=%0b done=%0b busy=1",
                 k, obs_plot[k], obs_done[k], obs_busy[k], exp_plot[k % 26], exp_done[k % 26]);
      end
    end
    n_cmp++;
    if (obs_state[25] !== 3'd0 || obs_state[26] !== 3'd1 || obs_state[51] !== 3'd0 || obs_state[52] !== 3'd1) begin
      n_err++;
      $display("FAIL b2b_state got st25=%0d st26=%0d st51=%0d st52=%0d exp 0,1,0,1",
               obs_state[25], obs_state[26], obs_state[51], obs_state[52]);
    end
    repeat (30) @(negedge clk);
  endtask

  task automatic test_full_default;
    int got_edge, n_plot, n_wall;
    logic busy_at_done;
    @(negedge clk);
    f_spr_x = 8'd118; f_spr_y = 8'd0; f_start = 1'b1;
    got_edge = -1; n_plot = 0; n_wall = 0; busy_at_done = 1'b0;
    for (int e = 0; e < 13000 && got_edge < 0; e++) begin
      @(negedge clk);
      f_start = 1'b0;
      if (f_plot) n_plot++;
      if (f_plot && f_colour == 3'b111) n_wall++;
      if (f_done) begin
        got_edge = e;
        busy_at_done = f_busy;
      end
    end
    n_cmp++;
    if (got_edge !== 12265) begin
      n_err++;
      $display("FAIL full_done_edge got %0d exp 12265", got_edge);
    end
    n_cmp++;
    if (n_plot !== 12012 || n_wall !== 12000) begin
      n_err++;
      $display("FAIL full_plot_counts got plots=%0d walls=%0d exp plots=12012 walls=12000", n_plot, n_wall);
    end
    @(negedge clk);
    n_cmp++;
    if (busy_at_done !== 1'b1 || f_busy !== 1'b0) begin
      n_err++;
      $display("FAIL full_busy got at_done=%0b after=%0b exp 1,0", busy_at_done, f_busy);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    ram[0] = 3'b000; ram[1] = 3'b010; ram[2] = 3'b000; ram[3] = 3'b000;
    test_reset();
    test_frames();
    test_reset_mid_frame();
    test_frames();
    test_ignore_start();
    test_back_to_back();
    test_full_default();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
